vlb_miss_ctl: RTL and testbench

Parametrised multi-channel VLB miss controller between N VLB request channels and a single memory port. It arbitrates miss requests and computes the memory line address (mcn) from satp and the VPN. It tracks up to DEPTH outstanding lines in order and extracts the 64-bit entry from each 512-bit response. It returns a per-channel fill, and per-channel kill suppresses fills for flushed requests.

---
 rtl/vlb_pkg.sv | 26 ++
 rtl/vlb_rr_arb.sv | 49 ++++
 rtl/vlb_miss_ctl.sv | 166 ++++++++++++++++
 tb/tb_vlb_miss_ctl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlb_pkg.sv
// Shared definitions for the VLB miss controller: PTE field layout,
// tracker metadata and the satp PPN slice.
package vlb_pkg;

    localparam int PTE_W       = 64;
    localparam int PTE_VLD     = 0;
    localparam int PTE_ATTR_LO = 1;
    localparam int PTE_ATTR_W  = 4;
    localparam int PTE_MPN_LO  = 10;
    localparam int PTE_ERR     = 63;

    localparam int LINE_W      = 512;
    localparam int WSEL_W      = 3;
    localparam int SATP_PPN_W  = 44;

    // Per-entry bookkeeping that does not depend on the channel/slot widths.
    typedef struct packed {
        logic              killed;
        logic [WSEL_W-1:0] wsel;
    } trk_meta_t;

    function automatic logic [SATP_PPN_W-1:0] satp_ppn(input logic [63:0] satp);
        return satp[SATP_PPN_W-1:0];
    endfunction

endpackage

// File: rtl/vlb_rr_arb.sv
// Round-robin arbiter for VLB miss channels: one-hot grant, priority
// pointer moves to the channel after each accepted winner.
module vlb_rr_arb #(
    parameter int N_CH = 3,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] req,
    input  logic            en,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [CH_W-1:0] ptr_q;
    logic            found;
    logic [CH_W-1:0] win;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_CH; i++) begin
            c = int'(ptr_q) + i;
            if (c >= N_CH) c = c - N_CH;
            if (!found && req[c]) begin
                found = 1'b1;
                win   = CH_W'(c);
            end
        end
    end

    assign gnt_any = found && en;
    assign gnt_idx = win;
    assign gnt     = gnt_any ? (N_CH'(1) << win) : '0;

    // NOTE: state registers use non-blocking <=; blocking = stays inside always_comb.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (gnt_any) begin
            ptr_q <= (int'(win) == N_CH - 1) ? '0 : win + CH_W'(1);
        end
    end

endmodule

// File: rtl/vlb_miss_ctl.sv
// VLB miss controller: arbitrates channel misses onto one memory port,
// tracks outstanding lines in order and returns the extracted PTE as a fill.
module vlb_miss_ctl
    import vlb_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int DEPTH = 4,
    parameter int IDX_W = 4,
    parameter int VPN_W = 27,
    parameter int MPN_W = 44,
    parameter int MCN_W = 58
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_CH-1:0]       vlb_req_i_valid,
    output logic [N_CH-1:0]       vlb_req_i_ready,
    input  logic [N_CH*IDX_W-1:0] vlb_req_i_bits_idx,
    input  logic [N_CH*VPN_W-1:0] vlb_req_i_bits_vpn,
    input  logic [N_CH-1:0]       vlb_kill_i,
    output logic [N_CH-1:0]       vlb_fill_o_valid,
    output logic [IDX_W-1:0]      vlb_fill_o_bits_idx,
    output logic                  vlb_fill_o_bits_vld,
    output logic                  vlb_fill_o_bits_err,
    output logic [MPN_W-1:0]      vlb_fill_o_bits_mpn,
    output logic [3:0]            vlb_fill_o_bits_attr,
    output logic                  vlb_busy_o,
    input  logic                  mem_req_o_ready,
    output logic                  mem_req_o_valid,
    output logic [MCN_W-1:0]      mem_req_o_bits_mcn,
    output logic                  mem_resp_i_ready,
    input  logic                  mem_resp_i_valid,
    input  logic [LINE_W-1:0]     mem_resp_i_bits_data,
    input  logic [63:0]           satp_i
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [IDX_W-1:0] idx;
        trk_meta_t        meta;
    } trk_ent_t;

    trk_ent_t         trk_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, iss_q;
    logic             req_vld_q;
    logic [MCN_W-1:0] req_mcn_q;

    logic [N_CH-1:0]  fill_valid_q;
    logic [IDX_W-1:0] fill_idx_q;
    logic             fill_vld_q, fill_err_q;
    logic [3:0]       fill_attr_q;
    logic [MPN_W-1:0] fill_mpn_q;

    logic [CH_W-1:0]  gnt_ch;
    logic             acc, acc_en, full, issue, resp_fire, head_killed;
    logic [IDX_W-1:0] acc_idx;
    logic [VPN_W-1:0] acc_vpn;
    trk_ent_t         new_ent, head;
    logic [PTE_W-1:0] pte;
    logic             satp_unused;

    assign satp_unused = ^satp_i[63:SATP_PPN_W];

    // Full comes from the registered count, so a same-cycle free cannot make room.
    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign acc_en = reset && !full && (!req_vld_q || mem_req_o_ready);

    vlb_rr_arb #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (vlb_req_i_valid & ~vlb_kill_i),
        .en      (acc_en),
        .gnt     (vlb_req_i_ready),
        .gnt_idx (gnt_ch),
        .gnt_any (acc)
    );

    assign acc_idx = vlb_req_i_bits_idx[int'(gnt_ch)*IDX_W +: IDX_W];
    assign acc_vpn = vlb_req_i_bits_vpn[int'(gnt_ch)*VPN_W +: VPN_W];
    assign new_ent = '{ch: gnt_ch, idx: acc_idx,
                       meta: '{killed: 1'b0, wsel: acc_vpn[WSEL_W-1:0]}};

    assign issue            = req_vld_q && mem_req_o_ready;
    assign mem_resp_i_ready = (iss_q != '0);
    assign resp_fire        = mem_resp_i_valid && mem_resp_i_ready;

    // A kill landing on the answering cycle still suppresses that fill.
    assign head        = trk_q[rd_ptr_q];
    assign head_killed = head.meta.killed || vlb_kill_i[head.ch];
    assign pte         = mem_resp_i_bits_data[{head.meta.wsel, 6'b0} +: PTE_W];

    always_comb begin
        cnt_d = cnt_q;
        if (acc && !resp_fire)      cnt_d = cnt_q + CNT_W'(1);
        else if (!acc && resp_fire) cnt_d = cnt_q - CNT_W'(1);
    end

    // NOTE: tracker payload is not reset; pointers and count define which slots are live.
    always_ff @(posedge clock) begin
        for (int e = 0; e < DEPTH; e++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (vlb_kill_i[c] && trk_q[e].ch == CH_W'(c)) trk_q[e].meta.killed <= 1'b1;
            end
        end
        if (acc) trk_q[wr_ptr_q] <= new_ent;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            iss_q        <= '0;
            req_vld_q    <= 1'b0;
            req_mcn_q    <= '0;
            vlb_busy_o   <= 1'b0;
            fill_valid_q <= '0;
            fill_idx_q   <= '0;
            fill_vld_q   <= 1'b0;
            fill_err_q   <= 1'b0;
            fill_attr_q  <= '0;
            fill_mpn_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            vlb_busy_o <= (cnt_d != '0);
            if (acc)       wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (resp_fire) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            if (issue && !resp_fire)      iss_q <= iss_q + CNT_W'(1);
            else if (!issue && resp_fire) iss_q <= iss_q - CNT_W'(1);

            if (acc) begin
                req_vld_q <= 1'b1;
                req_mcn_q <= MCN_W'(satp_ppn(satp_i)) + MCN_W'(acc_vpn >> 3);
            end else if (issue) begin
                req_vld_q <= 1'b0;
            end

            fill_valid_q <= (resp_fire && !head_killed) ? (N_CH'(1) << head.ch) : '0;
            if (resp_fire) begin
                fill_idx_q  <= head.idx;
                fill_vld_q  <= pte[PTE_VLD];
                fill_err_q  <= pte[PTE_ERR];
                fill_attr_q <= pte[PTE_ATTR_LO +: PTE_ATTR_W];
                fill_mpn_q  <= pte[PTE_MPN_LO +: MPN_W];
            end
        end
    end

    assign mem_req_o_valid      = req_vld_q;
    assign mem_req_o_bits_mcn   = req_mcn_q;
    assign vlb_fill_o_valid     = fill_valid_q;
    assign vlb_fill_o_bits_idx  = fill_idx_q;
    assign vlb_fill_o_bits_vld  = fill_vld_q;
    assign vlb_fill_o_bits_err  = fill_err_q;
    assign vlb_fill_o_bits_attr = fill_attr_q;
    assign vlb_fill_o_bits_mpn  = fill_mpn_q;

endmodule

// File: tb/tb_vlb_miss_ctl.sv
// Bench for vlb_miss_ctl: directed scenarios followed by random traffic, all
// checked against a queue-based model of outstanding misses.
module tb_vlb_miss_ctl;

    localparam int N_CH  = 3;
    localparam int DEPTH = 4;
    localparam int IDX_W = 4;
    localparam int VPN_W = 27;
    localparam int MPN_W = 44;
    localparam int MCN_W = 58;

    logic                  clock       = 1'b0;
    logic                  reset       = 1'b0;
    logic [N_CH-1:0]       valid       = '0;
    logic [N_CH-1:0]       ready;
    logic [N_CH*IDX_W-1:0] idx_bus     = '0;
    logic [N_CH*VPN_W-1:0] vpn_bus     = '0;
    logic [N_CH-1:0]       kill        = '0;
    logic [N_CH-1:0]       fill_v;
    logic [IDX_W-1:0]      fill_idx;
    logic                  fill_vld, fill_err;
    logic [MPN_W-1:0]      fill_mpn;
    logic [3:0]            fill_attr;
    logic                  busy;
    logic                  mreq_ready  = 1'b0;
    logic                  mreq_valid;
    logic [MCN_W-1:0]      mreq_mcn;
    logic                  mresp_ready;
    logic                  mresp_valid = 1'b0;
    logic [511:0]          mresp_data  = '0;
    logic [63:0]           satp        = '0;

    always #5 clock = ~clock;

    vlb_miss_ctl #(
        .N_CH(N_CH), .DEPTH(DEPTH), .IDX_W(IDX_W),
        .VPN_W(VPN_W), .MPN_W(MPN_W), .MCN_W(MCN_W)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .vlb_req_i_valid      (valid),
        .vlb_req_i_ready      (ready),
        .vlb_req_i_bits_idx   (idx_bus),
        .vlb_req_i_bits_vpn   (vpn_bus),
        .vlb_kill_i           (kill),
        .vlb_fill_o_valid     (fill_v),
        .vlb_fill_o_bits_idx  (fill_idx),
        .vlb_fill_o_bits_vld  (fill_vld),
        .vlb_fill_o_bits_err  (fill_err),
        .vlb_fill_o_bits_mpn  (fill_mpn),
        .vlb_fill_o_bits_attr (fill_attr),
        .vlb_busy_o           (busy),
        .mem_req_o_ready      (mreq_ready),
        .mem_req_o_valid      (mreq_valid),
        .mem_req_o_bits_mcn   (mreq_mcn),
        .mem_resp_i_ready     (mresp_ready),
        .mem_resp_i_valid     (mresp_valid),
        .mem_resp_i_bits_data (mresp_data),
        .satp_i               (satp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: miss entries in arrival order; the first m_iss of them have gone to memory.
    typedef struct {
        int               ch;
        logic [IDX_W-1:0] idx;
        logic [VPN_W-1:0] vpn;
        bit               killed;
        logic [MCN_W-1:0] mcn;
    } ment_t;

    ment_t            mq[$];
    int               m_iss = 0;
    int               m_ptr = 0;
    logic [N_CH-1:0]  e_fill_v = '0;
    logic [IDX_W-1:0] e_idx;
    logic             e_vld, e_err;
    logic [3:0]       e_attr;
    logic [MPN_W-1:0] e_mpn;
    logic [N_CH-1:0]  last_ready;
    int               fills[N_CH];

    task automatic model_reset();
        mq.delete();
        m_iss    = 0;
        m_ptr    = 0;
        e_fill_v = '0;
    endtask

    task automatic check_regs();
        check("mem_req_valid", 64'(mreq_valid), 64'(mq.size() > m_iss));
        if (mq.size() > m_iss) check("mem_req_mcn", 64'(mreq_mcn), 64'(mq[m_iss].mcn));
        check("mem_resp_ready", 64'(mresp_ready), 64'(m_iss > 0));
        check("busy", 64'(busy), 64'(mq.size() != 0));
        check("fill_valid", 64'(fill_v), 64'(e_fill_v));
        if (e_fill_v != '0) begin
            check("fill_idx", 64'(fill_idx), 64'(e_idx));
            check("fill_vld", 64'(fill_vld), 64'(e_vld));
            check("fill_err", 64'(fill_err), 64'(e_err));
            check("fill_attr", 64'(fill_attr), 64'(e_attr));
            check("fill_mpn", 64'(fill_mpn), 64'(e_mpn));
        end
        for (int c = 0; c < N_CH; c++) if (fill_v[c]) fills[c]++;
    endtask

    // One clock: check the combinational grant, advance the model, then check registers.
    task automatic tick();
        logic [N_CH-1:0]  elig, exp_gnt;
        logic [VPN_W-1:0] v;
        logic [63:0]      s, w;
        logic [511:0]     sh;
        ment_t            h, n;
        int               win, c;
        bit               req_v;
        #2;
        req_v = (mq.size() > m_iss);
        elig  = valid & ~kill;
        win   = -1;
        if (mq.size() < DEPTH && (!req_v || mreq_ready)) begin
            for (int i = 0; i < N_CH; i++) begin
                c = (m_ptr + i) % N_CH;
                if (win < 0 && elig[c]) win = c;
            end
        end
        exp_gnt    = (win >= 0) ? (N_CH'(1) << win) : '0;
        last_ready = ready;
        check("ready", 64'(ready), 64'(exp_gnt));

        e_fill_v = '0;
        if (mresp_valid && m_iss > 0) begin
            h = mq.pop_front();
            m_iss--;
            if (!h.killed && !kill[h.ch]) begin
                sh       = mresp_data >> (int'(h.vpn[2:0]) * 64);
                w        = sh[63:0];
                e_fill_v = N_CH'(1) << h.ch;
                e_idx    = h.idx;
                e_vld    = w[0];
                e_attr   = w[4:1];
                e_mpn    = w[53:10];
                e_err    = w[63];
            end
        end
        if (req_v && mreq_ready) m_iss++;
        foreach (mq[i]) if (kill[mq[i].ch]) mq[i].killed = 1'b1;
        if (win >= 0) begin
            v        = vpn_bus[win*VPN_W +: VPN_W];
            s        = {20'd0, satp[43:0]} + {40'd0, v[26:3]};
            n.ch     = win;
            n.idx    = idx_bus[win*IDX_W +: IDX_W];
            n.vpn    = v;
            n.killed = 1'b0;
            n.mcn    = s[MCN_W-1:0];
            mq.push_back(n);
            m_ptr = (win + 1) % N_CH;
        end
        @(posedge clock);
        #1;
        check_regs();
    endtask

    task automatic set_req(input int ch, input logic [IDX_W-1:0] i, input logic [VPN_W-1:0] v);
        idx_bus[ch*IDX_W +: IDX_W] = i;
        vpn_bus[ch*VPN_W +: VPN_W] = v;
    endtask

    task automatic rand_reqs();
        for (int c = 0; c < N_CH; c++) set_req(c, IDX_W'($urandom), VPN_W'($urandom));
    endtask

    task automatic rand_data();
        for (int j = 0; j < 16; j++) mresp_data[j*32 +: 32] = $urandom;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_ready", 64'(ready), 64'(0));
        check("rst_mem_req_valid", 64'(mreq_valid), 64'(0));
        check("rst_mem_resp_ready", 64'(mresp_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_fill_valid", 64'(fill_v), 64'(0));
        model_reset();
        valid       = '0;
        kill        = '0;
        mresp_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        check_regs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int f0, f2;
        foreach (fills[c]) fills[c] = 0;

        // Power-on reset, with requests already pending.
        valid = '1;
        #12;
        do_reset();

        // Single miss on channel 1.
        satp       = 64'h1000;
        mreq_ready = 1'b1;
        set_req(1, 4'd5, 27'h13);
        valid = 3'b010;
        tick();
        check("t1_mcn", 64'(mreq_mcn), 64'h1002);
        valid = '0;
        tick();
        check("t1_resp_ready", 64'(mresp_ready), 64'(1));
        mresp_data          = '0;
        mresp_data[255:192] = 64'h2C03;
        mresp_valid         = 1'b1;
        tick();
        mresp_valid = 1'b0;
        check("t1_fill_valid", 64'(fill_v), 64'(3'b010));
        check("t1_fill_idx", 64'(fill_idx), 64'd5);
        check("t1_fill_vld", 64'(fill_vld), 64'd1);
        check("t1_fill_attr", 64'(fill_attr), 64'd1);
        check("t1_fill_mpn", 64'(fill_mpn), 64'hB);
        check("t1_fill_err", 64'(fill_err), 64'd0);
        tick();

        // Round-robin with all channels requesting.
        do_reset();
        rand_reqs();
        satp  = {$urandom, $urandom};
        valid = '1;
        tick(); check("t2_rr0", 64'(last_ready), 64'(3'b001));
        tick(); check("t2_rr1", 64'(last_ready), 64'(3'b010));
        tick(); check("t2_rr2", 64'(last_ready), 64'(3'b100));
        tick(); check("t2_rr3", 64'(last_ready), 64'(3'b001));
        valid = '0;
        rand_data();
        mresp_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_data();
            tick();
        end
        mresp_valid = 1'b0;

        // Fill the tracker, hold, then free one entry.
        do_reset();
        rand_reqs();
        valid = '1;
        for (int k = 0; k < 6; k++) tick();
        check("t3_full_ready", 64'(last_ready), 64'(0));
        check("t3_full_busy", 64'(busy), 64'(1));
        mreq_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        mreq_ready  = 1'b1;
        mresp_valid = 1'b1;
        rand_data();
        tick();
        check("t3_free_cycle_ready", 64'(last_ready), 64'(0));
        mresp_valid = 1'b0;
        tick();
        check("t3_resume_ready", 64'(last_ready), 64'(3'b010));
        valid       = '0;
        mresp_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rand_data();
            tick();
        end
        mresp_valid = 1'b0;

        // Kill two outstanding ch0 misses; the interleaved ch2 miss still fills.
        do_reset();
        rand_reqs();
        f0 = fills[0];
        f2 = fills[2];
        valid = 3'b001; tick();
        valid = 3'b100; tick();
        valid = 3'b001; tick();
        valid = '0;     tick();
        kill = 3'b001;  tick();
        kill = '0;
        mresp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_data();
            tick();
        end
        mresp_valid = 1'b0;
        tick();
        check("t4_ch0_fills", 64'(fills[0] - f0), 64'(0));
        check("t4_ch2_fills", 64'(fills[2] - f2), 64'(1));

        // Kill on the answering cycle, together with a new ch2 request.
        f2    = fills[2];
        valid = 3'b100; tick();
        valid = '0;     tick();
        valid       = 3'b100;
        kill        = 3'b100;
        mresp_valid = 1'b1;
        rand_data();
        tick();
        check("t5_kill_ready", 64'(last_ready), 64'(0));
        valid       = '0;
        kill        = '0;
        mresp_valid = 1'b0;
        tick();
        check("t5_ch2_fills", 64'(fills[2] - f2), 64'(0));

        // Reset with three misses outstanding, then a stray response.
        valid = '1;
        for (int k = 0; k < 3; k++) tick();
        do_reset();
        mresp_valid = 1'b1;
        rand_data();
        tick();
        check("t6_stray_resp_ready", 64'(mresp_ready), 64'(0));
        check("t6_stray_fill", 64'(fill_v), 64'(0));
        mresp_valid = 1'b0;

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            rand_reqs();
            rand_data();
            valid = N_CH'($urandom);
            for (int c = 0; c < N_CH; c++) kill[c] = ($urandom_range(0, 15) == 0);
            mreq_ready  = ($urandom_range(0, 9) < 7);
            mresp_valid = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 31) == 0) satp = {$urandom, $urandom};
            tick();
        end

        valid       = '0;
        kill        = '0;
        mreq_ready  = 1'b1;
        mresp_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rand_data();
            tick();
        end
        check("drain_busy", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
